// File: rtl/or_trig_gen.sv
// ----------------------------------------------------------------------------
// or_trig_gen
//
// Purpose:
//   OR-trigger generator. Masked discriminator hits pass through a three-stage
//   OR tree (register, OR in groups of three, OR all groups). The rising edge
//   of the resulting raw hit starts a fixed-width trigger pulse. A dead-time
//   hold-off follows each pulse. The hit pattern that caused the most recent
//   accepted trigger is latched. Latency from the hit sample to trig high is
//   fixed at three cycles.
//
// Parameters:
//   N_CH      number of input channels (1..64)
//   STRETCH   trig high width in cycles (1..255)
//   DEADTIME  re-arm hold-off in cycles after the stretch (0..255)
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in          in   [N_CH] discriminator hits, synchronous to clk
//   mask        in   [N_CH] per-channel enable (1 = participates)
//   enable      in   global arm; 0 blocks new triggers only
//   trig        out  stretched trigger pulse
//   trig_rise   out  one-cycle pulse on the first cycle of trig
//   busy        out  high while firing or in dead time
//   chan_latch  out  [N_CH] masked hit pattern of the last accepted trigger
//   trig_count  out  [32] accepted-trigger count (wraps)
//
// Configuration:
//   OR_TRIG_COUNT_EN  when defined, the 32-bit trig_count counter is built;
//                     otherwise trig_count is tied to zero.
// ----------------------------------------------------------------------------
module or_trig_gen #(
  parameter int N_CH     = 18,
  parameter int STRETCH  = 4,
  parameter int DEADTIME = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] mask,
  input  logic            enable,
  output logic            trig,
  output logic            trig_rise,
  output logic            busy,
  output logic [N_CH-1:0] chan_latch,
  output logic [31:0]     trig_count
);

  localparam int         N_GRP        = (N_CH + 2) / 3;
  localparam logic [7:0] LP_FIRE_LOAD = 8'(STRETCH - 1);
  localparam logic [7:0] LP_DEAD_LOAD = (DEADTIME > 0) ? 8'(DEADTIME - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // OR pipeline
  // --------------------------------------------------------------------------
  logic [N_CH-1:0]    r_s1;
  logic [N_GRP-1:0]   r_s2;
  logic               r_raw;
  logic               r_raw_d;
  logic [N_CH-1:0]    r_pat_d1;
  logic [N_CH-1:0]    r_pat_d2;
  logic [3*N_GRP-1:0] w_pad;
  logic [N_GRP-1:0]   w_grp;
  logic               w_rise;

  // Stage-1 pattern zero-padded to a whole number of three-channel groups.
  always_comb begin
    w_pad           = '0;
    w_pad[N_CH-1:0] = r_s1;
  end

  generate
    for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
      assign w_grp[gi] = |w_pad[3*gi +: 3];
    end
  endgenerate

  // The pattern delay keeps the stage-1 hits aligned with r_raw. The pattern
  // that is latched on acceptance is then the pattern that produced the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_raw    <= 1'b0;
      r_raw_d  <= 1'b0;
      r_pat_d1 <= '0;
      r_pat_d2 <= '0;
    end else begin
      r_s1     <= in & mask;
      r_s2     <= w_grp;
      r_raw    <= |r_s2;
      r_raw_d  <= r_raw;
      r_pat_d1 <= r_s1;
      r_pat_d2 <= r_pat_d1;
    end
  end

  // A held hit produces a single rise.
  assign w_rise = r_raw & ~r_raw_d;

  // --------------------------------------------------------------------------
  // Trigger FSM
  // --------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic        w_accept;
  logic [N_CH-1:0] r_chan_latch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_chan_latch <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_chan_latch <= r_pat_d2;
      end
    end
  end

  // A rise is honoured only in IDLE. FIRE and DEAD run to completion whatever
  // the state of enable. A rise seen while the last DEAD cycle is leaving is
  // therefore dropped.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise && enable) begin
          w_accept     = 1'b1;
          w_state_next = ST_FIRE;
          w_cnt_next   = LP_FIRE_LOAD;
        end
      end
      ST_FIRE: begin
        if (r_cnt == 8'd0) begin
          if (DEADTIME == 0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_DEAD;
            w_cnt_next   = LP_DEAD_LOAD;
          end
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      ST_DEAD: begin
        if (r_cnt == 8'd0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  assign trig       = (r_state == ST_FIRE);
  // The counter holds its load value only on the first FIRE cycle.
  assign trig_rise  = (r_state == ST_FIRE) && (r_cnt == LP_FIRE_LOAD);
  assign busy       = (r_state != ST_IDLE);
  assign chan_latch = r_chan_latch;

  // --------------------------------------------------------------------------
  // Accepted-trigger counter
  // --------------------------------------------------------------------------
`ifdef OR_TRIG_COUNT_EN
  logic [31:0] r_trig_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_count <= 32'd0;
    end else if (w_accept) begin
      r_trig_count <= r_trig_count + 32'd1;
    end
  end

  assign trig_count = r_trig_count;
`else
  assign trig_count = 32'd0;
`endif

endmodule

// File: doc/or_trig_gen.md
OR_TRIG_GEN -- requirements
Module: or_trig_gen

Interface
REQ-001 SHALL have parameter N_CH, default 18: number of input channels (range 1..64).
REQ-002 SHALL have parameter STRETCH, default 4: trig high width in cycles (range 1..255).
REQ-003 SHALL have parameter DEADTIME, default 8: re-arm hold-off in cycles after stretch (range 0..255).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in  input  N_CH  discriminator hits, synchronous to clk.
REQ-007 SHALL have port mask  input  N_CH  per-channel enable; 1 = channel participates.
REQ-008 SHALL have port enable  input  1  global arm; 0 blocks new triggers.
REQ-009 SHALL have port trig  output  1  stretched trigger pulse.
REQ-010 SHALL have port trig_rise  output  1  one-cycle pulse on the first cycle of trig.
REQ-011 SHALL have port busy  output  1  high in FIRE and DEAD states.
REQ-012 SHALL have port chan_latch  output  N_CH  masked hit pattern that caused the last trigger.
REQ-013 SHALL have port trig_count  output  32  accepted-trigger count.

Function
REQ-014 SHALL register (in & mask) at edge k (stage 1).
REQ-015 SHALL OR stage 1 in groups of 3 channels, ceil(N_CH/3) groups, last group padded with 0, registered at edge k+1 (stage 2).
REQ-016 SHALL OR all groups into raw, registered at edge k+2 (stage 3); raw = OR of masked hits sampled at edge k.
REQ-017 SHALL carry the stage-1 pattern through a 2-deep delay aligned with raw.
REQ-018 SHALL detect rise = raw & ~raw_d, where raw_d is raw delayed one cycle; a held hit yields one rise only.
REQ-019 SHALL implement FSM IDLE, FIRE, DEAD.
REQ-020 IDLE: on rise & enable at edge k+3, go FIRE, load stretch counter with STRETCH-1, latch aligned pattern into chan_latch, increment trig_count.
REQ-021 FIRE: trig=1; decrement counter; at 0 go DEAD loaded with DEADTIME-1, or go IDLE if DEADTIME=0.
REQ-022 DEAD: trig=0, busy=1; decrement; at 0 go IDLE.
REQ-023 SHALL ignore rises in FIRE and DEAD (no retrigger, no extension, no count, chan_latch held).
REQ-024 SHALL make trig_rise=1 only in the first FIRE cycle; trig width exactly STRETCH cycles.
REQ-025 Hit-to-trig latency SHALL be fixed at 3 cycles: sampled at edge k, trig high after edge k+3.
REQ-026 enable falling during FIRE/DEAD SHALL NOT abort the sequence; it only blocks the next IDLE acceptance.
REQ-027 mask changes SHALL take effect for hits sampled at the next edge; pipeline contents are not flushed.
REQ-028 trig_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 A rise on the cycle DEAD exits SHALL be ignored; a rise in the first IDLE cycle SHALL be accepted.

Reset
REQ-030 rst_n low SHALL asynchronously clear all pipeline registers, raw_d, counters, chan_latch, and trig_count, and force IDLE.
REQ-031 Outputs during and after reset SHALL be trig=0, trig_rise=0, busy=0, chan_latch=0, trig_count=0.
REQ-032 Reset mid-FIRE or mid-DEAD SHALL terminate the pulse immediately; a hit held across reset release SHALL produce one trigger 3 cycles after its first post-reset sample.

Configuration
REQ-033 Macro OR_TRIG_COUNT_EN defined SHALL include the 32-bit trig_count counter per REQ-020/028.
REQ-034 Macro OR_TRIG_COUNT_EN undefined SHALL omit the counter and tie trig_count to 0; all other behaviour is identical.

Verification (N_CH=18, STRETCH=4, DEADTIME=8, OR_TRIG_COUNT_EN defined)
REQ-035 Bench SHALL drive in=0x00001 for one cycle with mask=0x3FFFF and enable=1 -> trig high cycles k+3..k+6, trig_rise at k+3, busy k+3..k+14, chan_latch=0x00001, trig_count=1.
REQ-036 Bench SHALL drive in[17]=1 with mask[17]=0 -> no trig, trig_count=0.
REQ-037 Bench SHALL hold in[5]=1 for 40 cycles -> exactly one trigger, trig_count=1.
REQ-038 Bench SHALL pulse in[0] at k, then in[9] at k+5 and k+13 -> first and third pulses trigger, second ignored, chan_latch=0x00200, trig_count=2.
REQ-039 Bench SHALL assert rst_n=0 at k+4 mid-FIRE -> trig, busy, and trig_count=0 immediately; a new hit after release triggers normally.
REQ-040 Bench SHALL preload trig_count=0xFFFFFFFF by force and fire once -> trig_count=0.
